// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, majority-vote sample points and
// the receive/transmit state encoding.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;

    localparam int unsigned VOTE_FIRST = 7;
    localparam int unsigned VOTE_MID   = 8;
    localparam int unsigned VOTE_LAST  = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/baud_tick_edge.sv
// Rising-edge detector for the 16x baud square wave; emits a one-cycle tick.
module baud_tick_edge (
    input  logic clk50MHz,
    input  logic resetN,
    input  logic baudClk,
    output logic tick
);

    logic baudClkQ;

    always_ff @(posedge clk50MHz or negedge resetN) begin
        if (!resetN) begin
            baudClkQ <= 1'b0;
        end else begin
            baudClkQ <= baudClk;
        end
    end

    assign tick = baudClk & ~baudClkQ;

endmodule

// File: rtl/uart_rx_16x.sv
// 8N1 UART receiver with 16x oversampling, majority-vote bit decisions,
// valid/ack byte handoff and sticky framing/overrun flags.
module uart_rx_16x
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = UART_DATA_BITS,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk50MHz,
    input  logic                 resetN,
    input  logic                 baudClk,
    input  logic                 rxSerial,
    input  logic                 rxAck,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxValid,
    output logic                 frameErr,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic                 tick;
    logic                 rxMeta;
    logic                 rxSync;
    uart_state_t          state;
    uart_state_t          stateNext;
    logic [CNT_W-1:0]     sampleCnt;
    logic [CNT_W-1:0]     curIdx;
    logic [BIT_W-1:0]     bitCnt;
    logic                 vote7;
    logic                 vote8;
    logic                 voteBit;
    logic                 active;
    logic                 voteNow;
    logic                 wrapNow;
    logic                 lastBit;
    logic                 shiftNow;
    logic                 loadByte;
    logic                 stopBad;
    logic [DATA_BITS-1:0] shiftReg;

    baud_tick_edge u_tick (
        .clk50MHz (clk50MHz),
        .resetN   (resetN),
        .baudClk  (baudClk),
        .tick     (tick)
    );

    always_ff @(posedge clk50MHz or negedge resetN) begin
        if (!resetN) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= rxSerial;
            rxSync <= rxMeta;
        end
    end

    // curIdx is the sample index of the current tick; the detecting tick
    // in IDLE counts as sample 0, so the first active tick is sample 1.
    always_comb begin
        curIdx  = (sampleCnt == CNT_W'(OVERSAMPLE - 1)) ? '0 : sampleCnt + 1'b1;
        voteBit = (vote7 & vote8) | (vote7 & rxSync) | (vote8 & rxSync);
        active  = tick && (state != IDLE);
        voteNow = active && (curIdx == CNT_W'(VOTE_LAST));
        wrapNow = active && (curIdx == '0);
        lastBit = (bitCnt == BIT_W'(DATA_BITS - 1));
    end

    always_ff @(posedge clk50MHz or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:  if (tick && !rxSync)         stateNext = START;
            START: if (voteNow && voteBit)      stateNext = IDLE;
                   else if (wrapNow)            stateNext = DATA;
            DATA:  if (wrapNow && lastBit)      stateNext = STOP;
            STOP:  if (voteNow)                 stateNext = IDLE;
            default:                            stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        shiftNow = (state == DATA) && voteNow;
        loadByte = (state == STOP) && voteNow && voteBit;
        stopBad  = (state == STOP) && voteNow && !voteBit;
    end

    always_ff @(posedge clk50MHz or negedge resetN) begin
        if (!resetN) begin
            sampleCnt <= '0;
            bitCnt    <= '0;
            vote7     <= 1'b1;
            vote8     <= 1'b1;
            shiftReg  <= '0;
        end else begin
            if (state == IDLE) begin
                sampleCnt <= '0;
                bitCnt    <= '0;
            end else if (tick) begin
                sampleCnt <= curIdx;
                if ((state == DATA) && wrapNow) begin
                    bitCnt <= bitCnt + 1'b1;
                end
            end
            if (active && (curIdx == CNT_W'(VOTE_FIRST))) begin
                vote7 <= rxSync;
            end
            if (active && (curIdx == CNT_W'(VOTE_MID))) begin
                vote8 <= rxSync;
            end
            if (shiftNow) begin
                shiftReg <= {voteBit, shiftReg[DATA_BITS-1:1]};
            end
        end
    end

    // A load in the same cycle as rxAck wins: the new byte stays valid and
    // is not counted as an overrun.
    always_ff @(posedge clk50MHz or negedge resetN) begin
        if (!resetN) begin
            rxData   <= '0;
            rxValid  <= 1'b0;
            frameErr <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (loadByte) begin
                rxData   <= shiftReg;
                rxValid  <= 1'b1;
                frameErr <= 1'b0;
            end else if (rxAck) begin
                rxValid  <= 1'b0;
            end
            if (stopBad) begin
                frameErr <= 1'b1;
            end
            if (loadByte && rxValid && !rxAck) begin
                overrun <= 1'b1;
            end else if (rxAck) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_16x.sv
// Self-checking bench for uart_rx_16x: frame-level reference model of the
// byte handoff and error flags, with directed and randomized frames.
module tb_uart_rx_16x;

    localparam int BAUD_HALF = 8;
    localparam int P         = 2 * BAUD_HALF;   // clk cycles per tick
    localparam int BIT       = 16 * P;          // clk cycles per bit
    localparam int FALL_MIN  = 153 * P;
    localparam int FALL_MAX  = 154 * P + 4;

    logic       clk50MHz;
    logic       resetN;
    logic       baudClk;
    logic       rxSerial;
    logic       rxAck;
    logic [7:0] rxData;
    logic       rxValid;
    logic       frameErr;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int bcnt   = 0;

    logic [7:0] m_data;
    bit         m_valid;
    bit         m_fe;
    bit         m_ovr;

    uart_rx_16x #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk50MHz (clk50MHz),
        .resetN   (resetN),
        .baudClk  (baudClk),
        .rxSerial (rxSerial),
        .rxAck    (rxAck),
        .rxData   (rxData),
        .rxValid  (rxValid),
        .frameErr (frameErr),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk50MHz = 1'b0;
    always #10 clk50MHz = ~clk50MHz;

    initial baudClk = 1'b0;
    always @(negedge clk50MHz) begin
        if (bcnt == BAUD_HALF - 1) begin
            bcnt    = 0;
            baudClk = ~baudClk;
        end else begin
            bcnt++;
        end
    end

    // Reference: what a correct receiver presents after a whole frame.
    task automatic model_frame(input logic [7:0] b, input bit stop_ok);
        if (stop_ok) begin
            if (m_valid) m_ovr = 1'b1;
            m_data  = b;
            m_valid = 1'b1;
            m_fe    = 1'b0;
        end else begin
            m_fe = 1'b1;
        end
    endtask

    task automatic model_ack();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // Drives one frame starting at cycle 0; reports when busy first fell and
    // when rxValid rose (cycles after the start edge), optionally acking.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                              input int ack_delay, input int idle_after,
                              output int fall_cyc, output int vrise_cyc);
        logic [9:0] bits;
        int  total;
        int  ack_at;
        bit  was_busy;
        bit  prev_valid;
        bits       = {stop_ok, b, 1'b0};
        total      = 10 * BIT;
        ack_at     = -1;
        was_busy   = 1'b0;
        prev_valid = rxValid;
        fall_cyc   = -1;
        vrise_cyc  = -1;
        for (int c = 0; c < total + idle_after; c++) begin
            @(negedge clk50MHz);
            if (c > 0) begin
                if (busy) was_busy = 1'b1;
                if (was_busy && !busy && fall_cyc < 0) fall_cyc = c;
                if (!prev_valid && rxValid && vrise_cyc < 0) begin
                    vrise_cyc = c;
                    if (ack_delay >= 0) ack_at = c + ack_delay;
                end
                if (ack_at >= 0 && c == ack_at + 1) begin
                    checks++;
                    if (rxValid !== 1'b0 || overrun !== 1'b0) begin
                        errors++;
                        $display("FAIL ack_clear: rxValid=%b overrun=%b expected 0 0", rxValid, overrun);
                    end
                end
                prev_valid = rxValid;
            end
            rxAck    = (ack_at >= 0 && c == ack_at);
            rxSerial = (c < total) ? bits[c / BIT] : 1'b1;
        end
        rxAck = 1'b0;
    endtask

    task automatic test_reset();
        resetN   = 1'b0;
        rxSerial = 1'b1;
        rxAck    = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk50MHz);
            if (i % 40 == 39) begin
                checks++;
                if ({rxValid, frameErr, overrun, busy} !== 4'b0 || rxData !== 8'h00) begin
                    errors++;
                    $display("FAIL reset_hold: data=%h v=%b fe=%b ovr=%b busy=%b expected all 0",
                             rxData, rxValid, frameErr, overrun, busy);
                end
            end
            rxSerial = 1'($urandom_range(0, 1));
        end
        rxSerial = 1'b1;
        @(negedge clk50MHz);
        resetN = 1'b1;
        repeat (3 * BIT) @(negedge clk50MHz);
        checks++;
        if ({rxValid, frameErr, overrun, busy} !== 4'b0 || rxData !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle: data=%h v=%b fe=%b ovr=%b busy=%b expected all 0",
                     rxData, rxValid, frameErr, overrun, busy);
        end
        m_data = 8'h00; m_valid = 0; m_fe = 0; m_ovr = 0;
    endtask

    task automatic test_single_byte();
        int fall, vrise;
        send_frame(8'hA5, 1'b1, 10, BIT, fall, vrise);
        model_frame(8'hA5, 1'b1);
        model_ack();
        checks++;
        if (vrise < FALL_MIN || vrise > FALL_MAX) begin
            errors++;
            $display("FAIL single_latency: rxValid rose at cycle %0d expected %0d..%0d", vrise, FALL_MIN, FALL_MAX);
        end
        checks++;
        if (rxData !== 8'hA5 || frameErr !== 1'b0 || overrun !== 1'b0 || rxValid !== 1'b0) begin
            errors++;
            $display("FAIL single_byte: data=%h fe=%b ovr=%b v=%b expected a5 0 0 0",
                     rxData, frameErr, overrun, rxValid);
        end
    endtask

    task automatic test_glitch();
        int  fall, vrise;
        bit  seen_busy;
        logic [7:0] b;
        b = 8'($urandom);
        send_frame(b, 1'b1, -1, BIT, fall, vrise);
        model_frame(b, 1'b1);
        seen_busy = 1'b0;
        rxSerial  = 1'b0;
        for (int i = 0; i < 3 * P; i++) begin
            @(negedge clk50MHz);
            if (busy) seen_busy = 1'b1;
        end
        rxSerial = 1'b1;
        for (int i = 0; i < 20 * P && busy; i++) @(negedge clk50MHz);
        checks++;
        if (!seen_busy || busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy: seen_busy=%b busy_end=%b expected 1 0", seen_busy, busy);
        end
        checks++;
        if (rxData !== m_data || rxValid !== m_valid || frameErr !== m_fe || overrun !== m_ovr) begin
            errors++;
            $display("FAIL glitch_flags: data=%h v=%b fe=%b ovr=%b expected %h %b %b %b",
                     rxData, rxValid, frameErr, overrun, m_data, m_valid, m_fe, m_ovr);
        end
        @(negedge clk50MHz) rxAck = 1'b1;
        @(negedge clk50MHz) rxAck = 1'b0;
        model_ack();
    endtask

    task automatic test_frame_error();
        int fall, vrise;
        send_frame(8'h3C, 1'b0, -1, 2 * BIT, fall, vrise);
        model_frame(8'h3C, 1'b0);
        checks++;
        if (fall < FALL_MIN || fall > FALL_MAX) begin
            errors++;
            $display("FAIL ferr_timing: busy fell at cycle %0d expected %0d..%0d", fall, FALL_MIN, FALL_MAX);
        end
        checks++;
        if (frameErr !== 1'b1 || rxValid !== 1'b0 || rxData !== m_data) begin
            errors++;
            $display("FAIL ferr_flag: fe=%b v=%b data=%h expected 1 0 %h", frameErr, rxValid, rxData, m_data);
        end
        send_frame(8'h81, 1'b1, -1, BIT, fall, vrise);
        model_frame(8'h81, 1'b1);
        checks++;
        if (rxData !== 8'h81 || rxValid !== 1'b1 || frameErr !== 1'b0) begin
            errors++;
            $display("FAIL ferr_recover: data=%h v=%b fe=%b expected 81 1 0", rxData, rxValid, frameErr);
        end
        @(negedge clk50MHz) rxAck = 1'b1;
        @(negedge clk50MHz) rxAck = 1'b0;
        model_ack();
    endtask

    task automatic test_back_to_back();
        int fall, vrise;
        send_frame(8'h11, 1'b1, -1, 0, fall, vrise);
        model_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1, -1, BIT, fall, vrise);
        model_frame(8'h22, 1'b1);
        checks++;
        if (rxData !== 8'h22 || overrun !== 1'b1 || rxValid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: data=%h ovr=%b v=%b expected 22 1 1", rxData, overrun, rxValid);
        end
        @(negedge clk50MHz) rxAck = 1'b1;
        @(negedge clk50MHz) rxAck = 1'b0;
        model_ack();
        checks++;
        if (overrun !== 1'b0 || rxValid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: ovr=%b v=%b expected 0 0", overrun, rxValid);
        end
    endtask

    task automatic test_reset_mid_frame();
        int fall, vrise;
        logic [9:0] bits;
        bits = {1'b1, 8'hFF, 1'b0};
        for (int c = 0; c < 5 * BIT + BIT / 2; c++) begin
            @(negedge clk50MHz);
            rxSerial = bits[c / BIT];
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_busy: busy=%b expected 1", busy);
        end
        resetN = 1'b0;
        @(negedge clk50MHz);
        checks++;
        if ({rxValid, frameErr, overrun, busy} !== 4'b0 || rxData !== 8'h00) begin
            errors++;
            $display("FAIL midreset_abort: data=%h v=%b fe=%b ovr=%b busy=%b expected all 0",
                     rxData, rxValid, frameErr, overrun, busy);
        end
        m_data = 8'h00; m_valid = 0; m_fe = 0; m_ovr = 0;
        repeat (4) @(negedge clk50MHz);
        resetN = 1'b1;
        repeat (6 * BIT) @(negedge clk50MHz);
        checks++;
        if (rxValid !== 1'b0 || busy !== 1'b0 || frameErr !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet: v=%b busy=%b fe=%b expected 0 0 0", rxValid, busy, frameErr);
        end
        send_frame(8'h0F, 1'b1, -1, BIT, fall, vrise);
        model_frame(8'h0F, 1'b1);
        checks++;
        if (rxData !== 8'h0F || rxValid !== 1'b1 || frameErr !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL midreset_next: data=%h v=%b fe=%b ovr=%b expected 0f 1 0 0",
                     rxData, rxValid, frameErr, overrun);
        end
        @(negedge clk50MHz) rxAck = 1'b1;
        @(negedge clk50MHz) rxAck = 1'b0;
        model_ack();
    endtask

    task automatic test_random();
        int fall, vrise, ackd;
        logic [7:0] b;
        bit stop_ok, pre_valid;
        for (int n = 0; n < 6; n++) begin
            b         = 8'($urandom);
            stop_ok   = ($urandom_range(0, 3) != 0);
            ackd      = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 20)) : -1;
            pre_valid = m_valid;
            send_frame(b, stop_ok, ackd, 2 * BIT, fall, vrise);
            model_frame(b, stop_ok);
            if (stop_ok && !pre_valid && ackd >= 0) model_ack();
            checks++;
            if (fall < FALL_MIN || fall > FALL_MAX) begin
                errors++;
                $display("FAIL rand_timing[%0d]: busy fell at cycle %0d expected %0d..%0d", n, fall, FALL_MIN, FALL_MAX);
            end
            checks++;
            if (rxData !== m_data || rxValid !== m_valid || frameErr !== m_fe || overrun !== m_ovr) begin
                errors++;
                $display("FAIL rand_frame[%0d]: data=%h v=%b fe=%b ovr=%b expected %h %b %b %b",
                         n, rxData, rxValid, frameErr, overrun, m_data, m_valid, m_fe, m_ovr);
            end
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk50MHz) rxAck = 1'b1;
                @(negedge clk50MHz) rxAck = 1'b0;
                model_ack();
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
